nibble_deser64: RTL and testbench
=================================

Name: nibble_deser64

Overview:
- Receiving end of the nibble-rotate path: a 64-bit word leaves as a stream of 4-bit nibbles and this block reassembles it.
- Accepts one nibble per cycle under a valid/ready handshake and shifts it into an assembly register, MSB-first or LSB-first.
- After 16 nibbles, moves the completed word to a one-entry output buffer, which is drained through a valid/ready handshake.
- Sits between a nibble source (a rotating shift register tapped at [63:60] or [3:0]) and any 64-bit consumer.

Parameters:
- DATA_W, 64, word width; must equal NIB_W*16.
- NIB_W, 4, nibble width.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous reset, active-high.
- nib_in  in  NIB_W  incoming nibble.
- nib_valid  in  1  nib_in is valid this cycle.
- nib_ready  out  1  block can accept a nibble this cycle (combinational).
- dir_r  in  1  0 = MSB-first (first nibble ends in [63:60]); 1 = LSB-first (first nibble ends in [3:0]).
- clear  in  1  synchronous discard of the partial word.
- data_out  out  DATA_W  completed word.
- out_valid  out  1  data_out holds an unconsumed word.
- out_ready  in  1  consumer accepts data_out this cycle.
- nib_count  out  4  nibbles held in the current partial word (0..15).

Behaviour:
- Reset (RST high, asynchronous): assembly register = 0, nib_count = 0, dir latch = 0, data_out = 0, out_valid = 0. RST mid-word discards the partial word and any buffered word.
- Nibble acceptance: a nibble is accepted when nib_valid & nib_ready & ~clear.
- nib_ready = ~clear & ~(out_valid & ~out_ready & nib_count==15).
  - Only the completing (16th) nibble stalls on a full, unconsumed buffer.
  - Nibbles 1..15 of the next word are accepted while the buffer is held.
- Direction latch: dir_r is captured on the accepted nibble while nib_count==0 and used for the whole word. Changes of dir_r mid-word are ignored.
- Shift on accept:
  - dir=0: asm <= {asm[DATA_W-NIB_W-1:0], nib_in}.
  - dir=1: asm <= {nib_in, asm[DATA_W-1:NIB_W]}.
- Count on accept:
  - nib_count 0..14: nib_count <= nib_count+1.
  - nib_count 15 (completion): data_out <= the shifted value including nib_in; out_valid <= 1; nib_count <= 0; asm <= 0.
- Output drain: out_valid & out_ready with no completion in the same cycle -> out_valid <= 0; data_out holds its last value.
- Simultaneous drain and completion: out_valid stays 1 and data_out takes the new word, with no bubble.
- Latency: data_out/out_valid update on the CLK edge that accepts the 16th nibble. Throughput is one word per 16 cycles sustained.
- clear:
  - Highest priority over acceptance: nib_count <= 0, asm <= 0, and nib_in is ignored that cycle.
  - Does not affect data_out or out_valid; a pending drain still completes.
- State summary:
  - COLLECT (nib_count 0..15).
  - Buffer EMPTY/FULL (out_valid).
  - No other states; there is no illegal state.

Test Plan:
- MSB-first: dir_r=0, feed 0x0,0x1,…,0xF back-to-back with out_ready=1 -> after the 16th edge data_out=0x0123456789ABCDEF, out_valid=1 for one cycle, nib_count=0.
- LSB-first: dir_r=1, same nibble sequence -> data_out=0xFEDCBA9876543210.
- Backpressure: out_ready=0 after word A=0x0123456789ABCDEF completes; feed 16 nibbles of 0xA.
  - Required: 15 are accepted; nib_ready=0 at nib_count=15.
  - Raise out_ready for one cycle: A is drained, 0xAAAAAAAAAAAAAAAA is loaded the same edge, and out_valid stays 1.
- Direction lock: start dir_r=0, toggle dir_r=1 after nibble 3 of 0x0..0xF -> result still 0x0123456789ABCDEF.
- Clear: feed 5 nibbles, assert clear one cycle with nib_valid=1 -> nib_count=0, nibble ignored. Next 16 nibbles of 0x5 -> data_out=0x5555555555555555.
- Async reset: assert RST between edges at nib_count=9 with out_valid=1 -> out_valid=0, data_out=0, nib_count=0 immediately; nib_ready=1 after release.

Source files
------------

// File: rtl/nibble_deser64.sv
// Reassembles a 64-bit word from 16 back-to-back nibbles (MSB- or LSB-first)
// and holds it in a one-entry output buffer drained by valid/ready.
module nibble_deser64 #(
  parameter int DATA_W = 64,
  parameter int NIB_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NIB_W-1:0]  nib_in,
  input  logic              nib_valid,
  output logic              nib_ready,
  input  logic              dir_r,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        nib_count
);
  localparam int NIBS = DATA_W / NIB_W;

  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] shifted;
  logic              dir_q;
  logic              dir_eff;
  logic              last;
  logic              accept;
  logic              complete;

  assign last      = (nib_count == 4'(NIBS - 1));
  // Only the word-completing nibble has to wait for the buffer to free up.
  assign nib_ready = ~clear & ~(out_valid & ~out_ready & last);
  assign accept    = nib_valid & nib_ready;
  assign complete  = accept & last;

  // Direction is sampled with the first nibble and frozen for the word.
  assign dir_eff = (nib_count == 4'd0) ? dir_r : dir_q;
  assign shifted = dir_eff ? {nib_in, asm_q[DATA_W-1:NIB_W]}
                           : {asm_q[DATA_W-NIB_W-1:0], nib_in};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      asm_q     <= '0;
      nib_count <= '0;
      dir_q     <= 1'b0;
    end else if (clear) begin
      asm_q     <= '0;
      nib_count <= '0;
    end else if (accept) begin
      if (nib_count == 4'd0) dir_q <= dir_r;
      if (last) begin
        asm_q     <= '0;
        nib_count <= '0;
      end else begin
        asm_q     <= shifted;
        nib_count <= nib_count + 4'd1;
      end
    end
  end

  // Completion wins over drain so a back-to-back word leaves no bubble.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (complete) begin
      data_out  <= shifted;
      out_valid <= 1'b1;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nibble_deser64.sv
// Directed bench for nibble_deser64: table-driven word assembly plus
// hand-written backpressure, clear and async-reset sequences.
module tb_nibble_deser64;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  nib_in = '0;
  logic        nib_valid = 1'b0;
  logic        nib_ready;
  logic        dir_r = 1'b0;
  logic        clear = 1'b0;
  logic [63:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  nib_count;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  nib;
    logic        v, dir, clr, ordy;
    logic [3:0]  ecnt;
    logic        evld;
    logic        chkd;
    logic [63:0] edata;
  } vec_t;

  vec_t tbl[$];

  nibble_deser64 #(.DATA_W(64), .NIB_W(4)) dut (
    .CLK(CLK), .RST(RST), .nib_in(nib_in), .nib_valid(nib_valid),
    .nib_ready(nib_ready), .dir_r(dir_r), .clear(clear),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .nib_count(nib_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, check #1 after the following rising edge.
  task automatic step(input string tag, input vec_t t);
    @(negedge CLK);
    nib_in = t.nib; nib_valid = t.v; dir_r = t.dir; clear = t.clr; out_ready = t.ordy;
    @(posedge CLK);
    #1;
    chk({tag, ".cnt"}, 64'(nib_count), 64'(t.ecnt));
    chk({tag, ".vld"}, 64'(out_valid), 64'(t.evld));
    if (t.chkd) chk({tag, ".data"}, data_out, t.edata);
  endtask

  function automatic vec_t mk(input logic [3:0] nib, input logic v, input logic dir,
                              input logic clr, input logic ordy, input logic [3:0] ecnt,
                              input logic evld, input logic chkd, input logic [63:0] edata);
    vec_t t;
    t.nib = nib; t.v = v; t.dir = dir; t.clr = clr; t.ordy = ordy;
    t.ecnt = ecnt; t.evld = evld; t.chkd = chkd; t.edata = edata;
    return t;
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst.vld",   64'(out_valid), 64'd0);
    chk("rst.data",  data_out, 64'd0);
    chk("rst.cnt",   64'(nib_count), 64'd0);
    chk("rst.ready", 64'(nib_ready), 64'd1);
    @(negedge CLK);
    RST = 1'b0;

    // Table: MSB-first word, drain, LSB-first word, drain, direction-lock word, drain
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(4'(i), 1, 0, 0, 1, 4'((i + 1) % 16), i == 15, i == 15, 64'h0123456789ABCDEF));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 64'h0123456789ABCDEF));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(4'(i), 1, 1, 0, 1, 4'((i + 1) % 16), i == 15, i == 15, 64'hFEDCBA9876543210));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 64'hFEDCBA9876543210));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(4'(i), 1, i >= 3, 0, 1, 4'((i + 1) % 16), i == 15, i == 15, 64'h0123456789ABCDEF));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 64'd0));
    foreach (tbl[i]) step($sformatf("tbl[%0d]", i), tbl[i]);

    // Backpressure: word A completes, then 0xA nibbles while A is held
    for (int i = 0; i < 16; i++)
      step($sformatf("bpA[%0d]", i), mk(4'(i), 1, 0, 0, 0, 4'((i + 1) % 16), i == 15, i == 15, 64'h0123456789ABCDEF));
    for (int i = 0; i < 15; i++)
      step($sformatf("bpB[%0d]", i), mk(4'hA, 1, 0, 0, 0, 4'(i + 1), 1, 1, 64'h0123456789ABCDEF));
    chk("bp.ready_stall", 64'(nib_ready), 64'd0);
    step("bp.stall", mk(4'hA, 1, 0, 0, 0, 15, 1, 1, 64'h0123456789ABCDEF));
    chk("bp.ready_still", 64'(nib_ready), 64'd0);
    step("bp.swap", mk(4'hA, 1, 0, 0, 1, 0, 1, 1, 64'hAAAAAAAAAAAAAAAA));
    step("bp.drain", mk(0, 0, 0, 0, 1, 0, 0, 1, 64'hAAAAAAAAAAAAAAAA));

    // Clear: 5 nibbles then clear with a valid nibble, which must be dropped
    for (int i = 0; i < 5; i++)
      step($sformatf("clr.pre[%0d]", i), mk(4'hF, 1, 0, 0, 1, 4'(i + 1), 0, 0, 64'd0));
    step("clr.hit", mk(4'hE, 1, 0, 1, 1, 0, 0, 0, 64'd0));
    chk("clr.ready", 64'(nib_ready), 64'd0);
    for (int i = 0; i < 16; i++)
      step($sformatf("clr.w5[%0d]", i), mk(4'h5, 1, 0, 0, 0, 4'((i + 1) % 16), i == 15, i == 15, 64'h5555555555555555));
    // Clear leaves the buffered word untouched
    step("clr.buf", mk(4'h7, 1, 0, 1, 0, 0, 1, 1, 64'h5555555555555555));

    // Async reset mid-word with a held word
    for (int i = 0; i < 9; i++)
      step($sformatf("ar.pre[%0d]", i), mk(4'h3, 1, 0, 0, 0, 4'(i + 1), 1, 0, 64'd0));
    @(negedge CLK);
    nib_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("ar.vld",  64'(out_valid), 64'd0);
    chk("ar.data", data_out, 64'd0);
    chk("ar.cnt",  64'(nib_count), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ar.ready", 64'(nib_ready), 64'd1);
    // First word after reset assembles MSB-first again
    for (int i = 0; i < 16; i++)
      step($sformatf("ar.post[%0d]", i), mk(4'(15 - i), 1, 0, 0, 1, 4'((i + 1) % 16), i == 15, i == 15, 64'hFEDCBA9876543210));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
